// File: rtl/seq_mul_pkg.sv
// Shared definitions for the batched multiply-accumulate stage that follows the
// 32-bit sequential shift-add multiplier.
//   MUL_N       : multiplier operand width (product bus is 2*MUL_N+1 bits)
//   ACC_GUARD   : guard bits added above the 2*MUL_N product width
//   acc_state_e : accumulator FSM states
//   count_width : width of a counter that must hold the values 0..batch
package seq_mul_pkg;

  localparam int unsigned MUL_N     = 32;
  localparam int unsigned ACC_GUARD = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  function automatic int unsigned count_width(input int unsigned batch);
    return (batch < 1) ? 1 : $clog2(batch + 1);
  endfunction

endpackage

// File: rtl/seq_mul_accum_valid_edge.sv
// Rising-edge detector on the multiplier's valid flag.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   valid : multiplier result-valid (may be held high for many cycles)
//   cap   : one-cycle strobe, high when valid rises
// The history register resets to 1 so a valid held high through reset does not
// produce a capture until it falls and rises again.
module seq_valid_edge (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  output logic cap
);

  logic valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b1;
    end else begin
      valid_q <= valid;
    end
  end

  assign cap = valid & ~valid_q;

endmodule

// File: rtl/seq_mul_accum.sv
// Batched accumulator downstream of the sequential multiplier. Sums BATCH
// products (one per rising edge of valid) and holds the sum on a ready/valid
// handshake.
//   clock     : rising-edge clock shared with the multiplier
//   reset     : synchronous active-low reset
//   prodt_end : product bus; bit 2N is the multiplier's internal carry, ignored
//   valid     : multiplier result-valid
//   clear     : synchronous batch abort, active-high
//   acc_out   : batch sum, stable while acc_valid is high
//   acc_valid : batch result available
//   acc_ready : consumer accepts acc_out
//   count     : products accumulated in the current batch
//   ovf       : sticky carry-out of the accumulator within this batch
//   drop      : sticky, a product arrived while holding and was discarded
module seq_mul_accum
  import seq_mul_pkg::*;
#(
  parameter int unsigned N     = MUL_N,
  parameter int unsigned ACC_W = 2 * N + ACC_GUARD,
  parameter int unsigned BATCH = 4,
  localparam int unsigned CntW = count_width(BATCH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2*N:0]     prodt_end,
  input  logic             valid,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [CntW-1:0]  count,
  output logic             ovf,
  output logic             drop
);

  localparam logic [CntW-1:0] BatchCnt = CntW'(BATCH);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic             acc_valid_q;
  logic [CntW-1:0]  count_q;
  logic             ovf_q;
  logic             drop_q;

  logic             cap;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CntW-1:0]  count_inc;
  logic             last_add;

  // The multiplier's internal carry bit is never part of the product.
  logic unused_prodt_carry;
  assign unused_prodt_carry = prodt_end[2*N];

  seq_valid_edge u_valid_edge (
    .clock (clock),
    .reset (reset),
    .valid (valid),
    .cap   (cap)
  );

  always_comb begin
    prod             = '0;
    prod[2*N-1:0]    = prodt_end[2*N-1:0];
    {carry, sum}     = {1'b0, acc_q} + {1'b0, prod};
    count_inc        = count_q + OneCnt;
  end

  assign last_add = (count_inc == BatchCnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else if (clear) begin
      // Clear wins over both capture and handshake; a coincident capture is lost.
      state_q     <= ACCUM;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (cap) begin
            acc_q   <= sum;
            ovf_q   <= ovf_q | carry;
            count_q <= count_inc;
            if (last_add) begin
              state_q     <= HOLD;
              acc_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            ovf_q <= 1'b0;
            if (cap) begin
              // Capture coincident with the handshake opens the next batch.
              acc_q   <= prod;
              count_q <= OneCnt;
              if (BATCH == 1) begin
                state_q     <= HOLD;
                acc_valid_q <= 1'b1;
              end else begin
                state_q     <= ACCUM;
                acc_valid_q <= 1'b0;
              end
            end else begin
              acc_q       <= '0;
              count_q     <= '0;
              state_q     <= ACCUM;
              acc_valid_q <= 1'b0;
            end
          end else if (cap) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign acc_out   = acc_q;
  assign acc_valid = acc_valid_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign drop      = drop_q;

endmodule
